cur_blk_pingpong: RTL and testbench
===================================

Name: cur_blk_pingpong

Overview:
- Parametrised ping-pong buffer holding the current block for motion estimation.
- Loads block pixels beat by beat from the frame-memory read port into one bank while the ME engine reads the other, complete bank as a flat parallel bus.
- Next generation of the current-block register: block size, pixel width and beat width are generic.
- Internal beat counter, valid/ready input handshake and explicit bank ownership replace external counter and bank-select control.

Parameters:
BLK_W, 8, block width in pixels
BLK_H, 8, block height in pixels
PIX_W, 8, bits per pixel
BEAT_PIX, 2, pixels per input beat; must divide BLK_W*BLK_H
(derived) NPIX = BLK_W*BLK_H; BEATS = NPIX/BEAT_PIX; CW = clog2(BEATS), minimum 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pause_in  in  1  write-side stall; no beat accepted while high
flush  in  1  synchronous clear of counters and bank flags
in_valid  in  1  input beat valid
in_data  in  BEAT_PIX*PIX_W  beat; upper pixel field = lower pixel index
in_ready  out  1  beat accepted when in_valid & in_ready
blk_valid  out  1  read bank holds a complete block
blk_data  out  NPIX*PIX_W  read-bank pixels; pixel i at [(NPIX-1-i)*PIX_W +: PIX_W]
blk_bank  out  1  index of bank presented on blk_data
blk_release  in  1  ME engine done with presented block
wr_beat  out  CW  beat index of next write within block
banks_full  out  2  per-bank full flags

Behaviour:
- Reset (rst low, async): both banks' pixel contents 0, full flags 00, wr_bank=0, rd_bank=0, beat count 0. Outputs: in_ready=0, blk_valid=0, blk_bank=0, wr_beat=0, banks_full=00, blk_data all zero.
- After reset release, in_ready rises combinationally from state. Deassertion timing is synchronised externally.
- in_ready = !pause_in & !full[wr_bank] & !flush.
- Accepted beat k (0..BEATS-1) writes pixels k*BEAT_PIX .. k*BEAT_PIX+BEAT_PIX-1 of bank wr_bank, raster order (pixel index = row*BLK_W+col).
  - Top PIX_W bits of in_data go to the lowest index.
  - Beat count increments by 1.
- Accepted beat BEATS-1:
  - full[wr_bank] set.
  - wr_bank toggles.
  - Beat count wraps to 0.
- No accepted beat: count, bank contents and wr_bank hold. Pause or backpressure mid-block resumes at the same beat.
- blk_valid = full[rd_bank]. blk_data = bank rd_bank contents, pure mux from bank registers. blk_bank = rd_bank.
- Latency: blk_valid high the cycle after the last beat is accepted, if that bank is rd_bank.
- blk_release while blk_valid:
  - full[rd_bank] cleared and rd_bank toggles on that edge.
  - blk_data/blk_valid reflect the other bank next cycle.
  - blk_release while !blk_valid is ignored.
- Release is honoured regardless of pause_in. blk_data is stable while blk_valid and no release.
- Simultaneous last-beat-write (bank A) and release (bank B): both take effect on the same edge.
- Both banks full: in_ready=0 until a release. in_ready is high the cycle after the release.
- flush (priority over write/release):
  - Beat count=0, full=00, wr_bank=rd_bank=0.
  - Pixel contents retained.
  - Partial block discarded.
- Reset mid-fill: partial block lost, state as reset.
- Elaboration error if BEATS*BEAT_PIX != NPIX.

Test Plan:
- Default params; beat k carries {8'(2k),8'(2k+1)}, 32 beats back-to-back -> blk_valid=1 one cycle after beat 31; pixel i = i (pixel 0=0x00 at MSB, pixel 63=0x3F); blk_bank=0; wr_beat=0; banks_full=01.
- Stream 64 beats, no release -> in_ready=0 after beat 63, banks_full=11. A held 65th beat is not taken. Pulse blk_release -> blk_bank=1 next cycle; in_ready=1; held beat lands at bank0 beat 0.
- pause_in high 5 cycles at beat 10 with in_valid held -> wr_beat stays 10, no bank change. Resume completes block with correct data at pixels 20..21.
- Bank1 last beat and blk_release of bank0 on the same edge -> next cycle banks_full=10, blk_bank=1, blk_valid=1.
- rst low at beat 17 -> all outputs reset values immediately (async). Reload of a full block -> correct from pixel 0.
- flush at beat 5 with bank0 full -> banks_full=00, wr_beat=0, blk_valid=0. Next 32 beats fill bank0 correctly.
- BLK_W=BLK_H=16, PIX_W=10, BEAT_PIX=4: 64 beats of incrementing pixels -> pixel 255=10'h0FF at LSB field.

Source files
------------

// File: rtl/cur_blk_pingpong.sv
// cur_blk_pingpong: two-bank store for the current motion-estimation block.
// Beats fill the write bank while the ME engine reads the other bank in parallel.
module cur_blk_pingpong #(
  parameter  int BLK_W    = 8,
  parameter  int BLK_H    = 8,
  parameter  int PIX_W    = 8,
  parameter  int BEAT_PIX = 2,
  localparam int NPIX     = BLK_W * BLK_H,
  localparam int BEATS    = NPIX / BEAT_PIX,
  localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pause_in,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [BEAT_PIX*PIX_W-1:0] in_data,
  output logic                      in_ready,
  output logic                      blk_valid,
  output logic [NPIX*PIX_W-1:0]     blk_data,
  output logic                      blk_bank,
  input  logic                      blk_release,
  output logic [CW-1:0]             wr_beat,
  output logic [1:0]                banks_full
);

  if (BEATS * BEAT_PIX != NPIX) begin : g_bad_beat
    $error("BEAT_PIX must divide BLK_W*BLK_H");
  end

  logic [PIX_W-1:0] bank_q [2][NPIX];
  logic [PIX_W-1:0] lane [BEAT_PIX];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] beat_q, beat_d;

  logic can_take;
  logic accept;
  logic last;
  logic rel;

  // Reset only gates the port; internal acceptance never depends on it.
  assign can_take = !pause_in & !full_q[wr_bank_q] & !flush;
  assign in_ready = rst & can_take;
  assign accept   = in_valid & can_take;
  assign last     = (beat_q == CW'(BEATS - 1));
  assign rel      = blk_release & full_q[rd_bank_q];

  assign blk_valid  = full_q[rd_bank_q];
  assign blk_bank   = rd_bank_q;
  assign wr_beat    = beat_q;
  assign banks_full = full_q;

  // Split the beat into pixels; the top field is the lowest pixel index.
  always_comb begin
    lane = '{default: '0};
    for (int j = 0; j < BEAT_PIX; j++) begin
      lane[j] = in_data[(BEAT_PIX-1-j)*PIX_W +: PIX_W];
    end
  end

  // Next-state for beat count, bank ownership and full flags.
  always_comb begin
    beat_d    = beat_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (flush) begin
      beat_d    = '0;
      full_d    = 2'b00;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end else begin
      // A release and a write can only target different banks.
      if (rel) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
      if (accept) begin
        if (last) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
          beat_d            = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q    <= '0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Pixel storage; flush leaves contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NPIX; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < NPIX; i++) begin
        if (beat_q == CW'(i / BEAT_PIX)) begin
          bank_q[wr_bank_q][i] <= lane[i % BEAT_PIX];
        end
      end
    end
  end

  // Flatten the read bank; pixel 0 sits in the top field.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < NPIX; i++) begin
      blk_data[(NPIX-1-i)*PIX_W +: PIX_W] = bank_q[rd_bank_q][i];
    end
  end

endmodule

// File: tb/tb_cur_blk_pingpong.sv
// tb_cur_blk_pingpong: scoreboard and vector checks for cur_blk_pingpong.
// Covers default geometry plus a 16x16, 10-bit, 4-pixel-beat instance.
module tb_cur_blk_pingpong;

  localparam int NP = 64;
  localparam int BW = NP * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          pause_in = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_ready;
  logic          blk_valid;
  logic [BW-1:0] blk_data;
  logic          blk_bank;
  logic          blk_release = 1'b0;
  logic [4:0]    wr_beat;
  logic [1:0]    banks_full;

  logic          b_valid = 1'b0;
  logic [39:0]   b_data = '0;
  logic          b_ready;
  logic          b_blk_valid;
  logic [2559:0] b_blk_data;
  logic          b_blk_bank;
  logic [5:0]    b_wr_beat;
  logic [1:0]    b_full;

  cur_blk_pingpong dut (
    .clk(clk), .rst(rst), .pause_in(pause_in), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_bank(blk_bank),
    .blk_release(blk_release), .wr_beat(wr_beat), .banks_full(banks_full)
  );

  cur_blk_pingpong #(.BLK_W(16), .BLK_H(16), .PIX_W(10), .BEAT_PIX(4)) dut_big (
    .clk(clk), .rst(rst), .pause_in(1'b0), .flush(1'b0),
    .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .blk_valid(b_blk_valid), .blk_data(b_blk_data), .blk_bank(b_blk_bank),
    .blk_release(1'b0), .wr_beat(b_wr_beat), .banks_full(b_full)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic          bank;
    logic [BW-1:0] img;
  } blk_t;
  blk_t sbq[$];

  typedef struct {
    logic pause;
    logic fl;
    logic exp_ready;
  } vec_t;

  logic [7:0] cur_pix [NP];
  int   mcnt = 0;
  logic mwb = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_img(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    mcnt = 0;
    mwb = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] d);
    blk_t e;
    cur_pix[mcnt*2]   = d[15:8];
    cur_pix[mcnt*2+1] = d[7:0];
    mcnt++;
    if (mcnt == NP / 2) begin
      e.bank = mwb;
      e.img = '0;
      for (int i = 0; i < NP; i++) e.img[(NP-1-i)*8 +: 8] = cur_pix[i];
      sbq.push_back(e);
      mwb = ~mwb;
      mcnt = 0;
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    #1;
    while (!in_ready && n <= 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n > 200) begin
      chk("send_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(d);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic fill(input int n, input int base);
    for (int k = 0; k < n; k++) send({8'(base + 2*k), 8'(base + 2*k + 1)});
  endtask

  task automatic sb_compare(input string nm);
    blk_t e;
    chk({nm, "_valid"}, blk_valid, 1'b1);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 1'b0, 1'b1);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_bank"}, blk_bank, e.bank);
      chk_img({nm, "_data"}, blk_data, e.img);
    end
  endtask

  task automatic pulse_release();
    blk_release = 1'b1;
    @(posedge clk); #1;
    blk_release = 1'b0;
  endtask

  task automatic release_chk(input string nm);
    sb_compare(nm);
    pulse_release();
  endtask

  vec_t vt [4];
  logic [BW-1:0] exp_img;
  int nbig;

  initial begin
    vt[0] = '{pause: 1'b0, fl: 1'b0, exp_ready: 1'b1};
    vt[1] = '{pause: 1'b1, fl: 1'b0, exp_ready: 1'b0};
    vt[2] = '{pause: 1'b0, fl: 1'b1, exp_ready: 1'b0};
    vt[3] = '{pause: 1'b1, fl: 1'b1, exp_ready: 1'b0};

    #3;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", blk_valid, 1'b0);
    chk("rst_bank", blk_bank, 1'b0);
    chk("rst_beat", wr_beat, 5'd0);
    chk("rst_full", banks_full, 2'b00);
    chk_img("rst_data", blk_data, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      pause_in = vt[v].pause;
      flush = vt[v].fl;
      #1;
      chk($sformatf("vec%0d_ready", v), in_ready, vt[v].exp_ready);
    end
    pause_in = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;

    // one block, pixel i = i
    fill(31, 0);
    chk("t1_not_yet", blk_valid, 1'b0);
    send({8'd62, 8'd63});
    for (int i = 0; i < NP; i++) exp_img[(NP-1-i)*8 +: 8] = 8'(i);
    chk("t1_valid", blk_valid, 1'b1);
    chk("t1_bank", blk_bank, 1'b0);
    chk("t1_beat", wr_beat, 5'd0);
    chk("t1_full", banks_full, 2'b01);
    chk_img("t1_data", blk_data, exp_img);

    // both banks full, held beat waits for a release
    fill(32, 64);
    chk("t2_full", banks_full, 2'b11);
    in_valid = 1'b1;
    in_data = 16'hAABB;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_held_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("t2_held_beat", wr_beat, 5'd0);
    end
    sb_compare("t2_rel0");
    blk_release = 1'b1;
    @(posedge clk); #1;
    blk_release = 1'b0;
    chk("t2_bank", blk_bank, 1'b1);
    chk("t2_valid", blk_valid, 1'b1);
    chk("t2_ready", in_ready, 1'b1);
    chk("t2_full2", banks_full, 2'b10);
    @(posedge clk);
    model_accept(16'hAABB);
    #1;
    in_valid = 1'b0;
    chk("t2_landed", wr_beat, 5'd1);

    // pause at beat 10 with valid held
    for (int k = 1; k < 10; k++) send({8'(16 + 2*k), 8'(17 + 2*k)});
    chk("t3_beat10", wr_beat, 5'd10);
    in_valid = 1'b1;
    in_data = 16'h5AA5;
    pause_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t3_pause_beat", wr_beat, 5'd10);
      chk("t3_pause_full", banks_full, 2'b10);
    end
    pause_in = 1'b0;
    send(16'h5AA5);
    for (int k = 11; k < 32; k++) send({8'(16 + 2*k), 8'(17 + 2*k)});
    chk("t3_full", banks_full, 2'b11);
    release_chk("t3_rel1");
    chk("t3_pix20_21", blk_data[(NP-1-21)*8 +: 16], 16'h5AA5);
    release_chk("t3_rel0");

    // last beat into bank1 on the same edge as releasing bank0
    fill(32, 100);
    release_chk("t4_pre");
    fill(32, 3);
    fill(31, 150);
    sb_compare("t4_rel0");
    blk_release = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hC3D4;
    #1;
    chk("t4_ready", in_ready, 1'b1);
    @(posedge clk);
    model_accept(16'hC3D4);
    #1;
    blk_release = 1'b0;
    in_valid = 1'b0;
    chk("t4_full", banks_full, 2'b10);
    chk("t4_bank", blk_bank, 1'b1);
    chk("t4_valid", blk_valid, 1'b1);
    release_chk("t4_rel1");

    // asynchronous reset mid-fill
    fill(17, 40);
    chk("t5_beat17", wr_beat, 5'd17);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_ready", in_ready, 1'b0);
    chk("t5_valid", blk_valid, 1'b0);
    chk("t5_bank", blk_bank, 1'b0);
    chk("t5_beat", wr_beat, 5'd0);
    chk("t5_full", banks_full, 2'b00);
    chk_img("t5_data", blk_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    fill(32, 7);
    release_chk("t5_reload");

    // flush at beat 5 with bank0 full
    fill(32, 11);
    release_chk("t6_pre");
    fill(32, 20);
    fill(5, 90);
    chk("t6_beat5", wr_beat, 5'd5);
    chk("t6_pre_full", banks_full, 2'b01);
    flush = 1'b1;
    #1;
    chk("t6_flush_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_full", banks_full, 2'b00);
    chk("t6_beat", wr_beat, 5'd0);
    chk("t6_valid", blk_valid, 1'b0);
    model_reset();
    pulse_release();
    chk("t6_idle_rel", blk_bank, 1'b0);
    fill(32, 33);
    chk("t6_refill", banks_full, 2'b01);
    release_chk("t6_rel");

    // 16x16, 10-bit pixels, four per beat
    for (int k = 0; k < 64; k++) begin
      int n;
      n = 0;
      b_valid = 1'b1;
      b_data = {10'(4*k), 10'(4*k + 1), 10'(4*k + 2), 10'(4*k + 3)};
      #1;
      while (!b_ready && n <= 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n > 200) chk("big_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      b_valid = 1'b0;
    end
    chk("big_valid", b_blk_valid, 1'b1);
    chk("big_full", b_full, 2'b01);
    chk("big_beat", b_wr_beat, 6'd0);
    chk("big_pix255", b_blk_data[9:0], 10'h0FF);
    chk("big_pix0", b_blk_data[2559:2550], 10'h000);
    nbig = 0;
    for (int i = 0; i < 256; i++) begin
      if (b_blk_data[(255-i)*10 +: 10] !== 10'(i)) nbig++;
    end
    chk("big_all_pix", nbig, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
